// File: rtl/reg_transfer_sequencer.sv
`timescale 1ns/1ps
// reg_transfer_sequencer
//   Command-side initiator for the 8 x 16-bit main_register bank. It accepts
//   encoded transfer instructions on a valid/ready channel. It drives the
//   bank's source/dest/move/in/data controls with mutually exclusive strobes.
//   It reads a register back through the bank's combinational out path and
//   returns the value on a valid/ready response channel.
//
// Ports
//   clk, rst_n           clock (rising edge), asynchronous active-low reset
//   instr_valid/ready    instruction handshake
//   instr[23:0]          [23:22] op, [21:19] src, [18:16] dst, [15:0] imm
//                        op: 00 NOP, 01 IN, 10 MOVE, 11 READ
//   rf_source, rf_dest   bank source / destination selects
//   rf_move, rf_in       bank MOVE / IN strobes (never both high)
//   rf_data              bank immediate data
//   rf_out               bank read data, reg[rf_source], combinational
//   rsp_valid/ready      read response handshake
//   rsp_data             captured register value
//   busy                 high whenever the FSM is not in IDLE
//   op_count             completed operations, wraps
//
// Every output comes straight from a flop.
module reg_transfer_sequencer #(
  parameter int HOLD_CYCLES = 1,
  parameter int CNT_W       = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             instr_valid,
  output logic             instr_ready,
  input  logic [23:0]      instr,
  output logic [2:0]       rf_source,
  output logic [2:0]       rf_dest,
  output logic             rf_move,
  output logic             rf_in,
  output logic [15:0]      rf_data,
  input  logic [15:0]      rf_out,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [15:0]      rsp_data,
  output logic             busy,
  output logic [CNT_W-1:0] op_count
);

  localparam int DATA_W = 16;

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_EXEC   = 2'd1;
  localparam logic [1:0] S_SETTLE = 2'd2;
  localparam logic [1:0] S_RESP   = 2'd3;

  localparam logic [1:0] OP_NOP  = 2'b00;
  localparam logic [1:0] OP_IN   = 2'b01;
  localparam logic [1:0] OP_MOVE = 2'b10;
  localparam logic [1:0] OP_READ = 2'b11;

  localparam logic [3:0] HOLD = 4'(HOLD_CYCLES);

  generate
    if (HOLD_CYCLES < 1 || HOLD_CYCLES > 15) begin : g_bad_hold
      $error("reg_transfer_sequencer: HOLD_CYCLES must be in 1..15");
    end
  endgenerate

  logic [1:0]        state;
  logic [1:0]        op_q;
  logic [DATA_W-1:0] imm_q;
  logic [3:0]        cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= S_IDLE;
      op_q        <= OP_NOP;
      imm_q       <= '0;
      cnt         <= '0;
      instr_ready <= 1'b1;
      busy        <= 1'b0;
      rf_source   <= '0;
      rf_dest     <= '0;
      rf_move     <= 1'b0;
      rf_in       <= 1'b0;
      rf_data     <= '0;
      rsp_valid   <= 1'b0;
      rsp_data    <= '0;
      op_count    <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (instr_valid) begin
            op_q  <= instr[23:22];
            imm_q <= instr[15:0];
            case (instr[23:22])
              OP_NOP: op_count <= op_count + 1'b1;
              OP_IN, OP_MOVE: begin
                // Selects are presented now; strobes follow one edge later so
                // the bank sees stable addresses before the first strobe edge.
                state       <= S_EXEC;
                cnt         <= HOLD;
                instr_ready <= 1'b0;
                busy        <= 1'b1;
                rf_source   <= instr[21:19];
                rf_dest     <= instr[18:16];
              end
              OP_READ: begin
                // One cycle for the registered source select to reach the
                // bank, then the read path is sampled on the following edge.
                state       <= S_SETTLE;
                cnt         <= 4'd1;
                instr_ready <= 1'b0;
                busy        <= 1'b1;
                rf_source   <= instr[21:19];
              end
            endcase
          end
        end

        S_EXEC: begin
          if (cnt != 4'd0) begin
            cnt <= cnt - 4'd1;
            if (op_q == OP_IN) begin
              rf_in   <= 1'b1;
              rf_data <= imm_q;
            end else begin
              rf_move <= 1'b1;
              rf_data <= '0;
            end
          end else begin
            rf_in       <= 1'b0;
            rf_move     <= 1'b0;
            rf_data     <= '0;
            rf_source   <= '0;
            rf_dest     <= '0;
            op_count    <= op_count + 1'b1;
            state       <= S_IDLE;
            instr_ready <= 1'b1;
            busy        <= 1'b0;
          end
        end

        S_SETTLE: begin
          if (cnt != 4'd0) begin
            cnt <= cnt - 4'd1;
          end else begin
            rsp_data  <= rf_out;
            rsp_valid <= 1'b1;
            rf_source <= '0;
            state     <= S_RESP;
          end
        end

        S_RESP: begin
          if (rsp_ready) begin
            rsp_valid   <= 1'b0;
            op_count    <= op_count + 1'b1;
            state       <= S_IDLE;
            instr_ready <= 1'b1;
            busy        <= 1'b0;
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_reg_transfer_sequencer.sv
`timescale 1ns/1ps
module tb_reg_transfer_sequencer;

  localparam int H = 3;

  logic        clk;
  logic        rst_n;
  logic        instr_valid;
  logic        instr_ready;
  logic [23:0] instr;
  logic [2:0]  rf_source;
  logic [2:0]  rf_dest;
  logic        rf_move;
  logic        rf_in;
  logic [15:0] rf_data;
  logic [15:0] rf_out;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [15:0] rsp_data;
  logic        busy;
  logic [15:0] op_count;

  reg_transfer_sequencer #(.HOLD_CYCLES(H), .CNT_W(16)) dut (
    .clk(clk), .rst_n(rst_n),
    .instr_valid(instr_valid), .instr_ready(instr_ready), .instr(instr),
    .rf_source(rf_source), .rf_dest(rf_dest), .rf_move(rf_move), .rf_in(rf_in),
    .rf_data(rf_data), .rf_out(rf_out),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data),
    .busy(busy), .op_count(op_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural register bank driven by the sequencer.
  logic [15:0] bank [8];
  assign rf_out = bank[rf_source];
  always @(posedge clk) begin
    if (rf_in) bank[rf_dest] <= rf_data;
    else if (rf_move) bank[rf_dest] <= bank[rf_source];
  end

  int n_chk  = 0;
  int n_pass = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
  endtask

  logic [15:0] shadow [8];
  logic [15:0] sb [$];
  logic [2:0]  cur_src, cur_dst;
  logic [15:0] cur_imm;
  int          exp_ops = 0;
  int          run = 0;
  bit          nop_phase = 0;
  bit          nz = 0;

  // Strobe content, exclusivity, pulse length and response scoreboard.
  always @(negedge clk) begin
    if (!rst_n) begin
      run <= 0;
    end else begin
      if (rf_in || rf_move) begin
        check("excl", 32'(rf_in & rf_move), 32'd0);
        check("strobe_busy", 32'(busy), 32'd1);
        if (rf_in) begin
          check("in_dest", 32'(rf_dest), 32'(cur_dst));
          check("in_data", 32'(rf_data), 32'(cur_imm));
        end else begin
          check("mv_src", 32'(rf_source), 32'(cur_src));
          check("mv_dest", 32'(rf_dest), 32'(cur_dst));
          check("mv_data", 32'(rf_data), 32'd0);
        end
        run <= run + 1;
      end else if (run != 0) begin
        check("strobe_len", 32'(run), 32'(H));
        run <= 0;
      end
      if (rsp_valid && rsp_ready) begin
        if (sb.size() == 0) check("sb_empty", 32'd1, 32'd0);
        else check("rsp_data", 32'(rsp_data), 32'(sb.pop_front()));
      end
      if (nop_phase && (rf_in || rf_move || rf_data != 16'd0 || rf_dest != 3'd0 || rf_source != 3'd0))
        nz <= 1'b1;
    end
  end

  task automatic send(input logic [1:0] op, input logic [2:0] src, input logic [2:0] dst,
                      input logic [15:0] imm, input bit keep);
    int g = 0;
    instr = {op, src, dst, imm};
    instr_valid = 1'b1;
    while (!instr_ready && g < 500) begin
      @(posedge clk); #1; g++;
    end
    if (g >= 500) check("acc_timeout", 32'(g), 32'd0);
    @(posedge clk); #1;
    case (op)
      2'b01: begin shadow[dst] = imm; cur_dst = dst; cur_imm = imm; end
      2'b10: begin shadow[dst] = shadow[src]; cur_src = src; cur_dst = dst; end
      2'b11: sb.push_back(shadow[src]);
      default: ;
    endcase
    exp_ops++;
    // Scramble the bus while busy: the latched copy must be used.
    instr = 24'($urandom);
    if (!keep) instr_valid = 1'b0;
  endtask

  task automatic wait_ready(input string tag, input int exp_n);
    int n = 0;
    do begin
      @(posedge clk); #1; n++;
    end while (!instr_ready && n < 500);
    check(tag, 32'(n), 32'(exp_n));
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    exp_ops = 0;
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog expired");
    $fatal(1, "timeout");
  end

  initial begin
    instr_valid = 1'b0;
    instr       = '0;
    rsp_ready   = 1'b1;
    do_reset();
    check("rst_ready", 32'(instr_ready), 32'd1);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    check("rst_rsp_data", 32'(rsp_data), 32'd0);
    check("rst_count", 32'(op_count), 32'd0);
    check("rst_rf", 32'({rf_in, rf_move, rf_source, rf_dest, rf_data}), 32'd0);

    // IN then READ back
    send(2'b01, 3'd0, 3'd3, 16'h00A5, 1'b0);
    wait_ready("in_latency", H + 1);
    check("count_in", 32'(op_count), 32'd1);
    send(2'b11, 3'd3, 3'd0, 16'h0, 1'b0);
    wait_ready("rd_latency", 3);
    check("count_rd", 32'(op_count), 32'd2);

    // IN, MOVE, READ
    send(2'b01, 3'd0, 3'd0, 16'h0002, 1'b0);
    wait_ready("in_r0", H + 1);
    send(2'b10, 3'd0, 3'd1, 16'hFFFF, 1'b0);
    wait_ready("mv_latency", H + 1);
    send(2'b11, 3'd1, 3'd0, 16'h0, 1'b0);
    wait_ready("rd_r1", 3);
    check("count_mv", 32'(op_count), 32'(exp_ops));

    // Back-to-back INs with instr_valid held high
    for (int i = 0; i < 4; i++) begin
      send(2'b01, 3'd7, 3'(i), 16'($urandom), (i != 3));
      wait_ready("b2b_ready_low", H + 1);
    end
    for (int i = 0; i < 4; i++) begin
      send(2'b11, 3'(i), 3'd0, 16'h0, 1'b0);
      wait_ready("b2b_rd", 3);
    end
    check("count_b2b", 32'(op_count), 32'(exp_ops));

    // Response stall
    send(2'b01, 3'd0, 3'd4, 16'hBEEF, 1'b0);
    wait_ready("in_r4", H + 1);
    rsp_ready = 1'b0;
    send(2'b11, 3'd4, 3'd0, 16'h0, 1'b0);
    repeat (2) @(posedge clk);
    #1;
    for (int i = 0; i < 10; i++) begin
      check("stall_valid", 32'(rsp_valid), 32'd1);
      check("stall_data", 32'(rsp_data), 32'h0000BEEF);
      check("stall_ready", 32'(instr_ready), 32'd0);
      instr_valid = 1'b1;
      instr = 24'($urandom);
      @(posedge clk); #1;
    end
    instr_valid = 1'b0;
    rsp_ready = 1'b1;
    @(posedge clk); #1;
    check("hs_valid_drop", 32'(rsp_valid), 32'd0);
    check("hs_ready", 32'(instr_ready), 32'd1);
    @(posedge clk); #1;
    check("idle_after_hs", 32'(busy), 32'd0);
    check("count_stall", 32'(op_count), 32'(exp_ops));

    // MOVE onto itself leaves the register unchanged
    send(2'b10, 3'd2, 3'd2, 16'h0, 1'b0);
    wait_ready("mv_self", H + 1);
    send(2'b11, 3'd2, 3'd0, 16'h0, 1'b0);
    wait_ready("rd_self", 3);
    check("count_self", 32'(op_count), 32'(exp_ops));

    // Reset during the second strobe cycle of an IN
    send(2'b01, 3'd0, 3'd5, 16'h1234, 1'b0);
    repeat (2) @(posedge clk);
    #2;
    check("mid_exec_in", 32'(rf_in), 32'd1);
    rst_n = 1'b0;
    #1;
    check("async_in_clear", 32'(rf_in), 32'd0);
    check("async_count", 32'(op_count), 32'd0);
    check("async_busy", 32'(busy), 32'd0);
    exp_ops = 0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    check("post_rst_ready", 32'(instr_ready), 32'd1);
    send(2'b01, 3'd0, 3'd6, 16'h5A5A, 1'b0);
    wait_ready("in_after_rst", H + 1);
    send(2'b11, 3'd6, 3'd0, 16'h0, 1'b0);
    wait_ready("rd_r6", 3);
    send(2'b11, 3'd5, 3'd0, 16'h0, 1'b0);
    wait_ready("rd_r5", 3);
    check("count_after_rst", 32'(op_count), 32'd3);

    // NOP stream wraps the counter
    do_reset();
    instr = {2'b00, 22'h2ABCDE};
    nop_phase = 1'b1;
    instr_valid = 1'b1;
    repeat (65535) @(posedge clk);
    #1;
    check("nop_all_ones", 32'(op_count), 32'h0000FFFF);
    check("nop_ready", 32'(instr_ready), 32'd1);
    @(posedge clk); #1;
    instr_valid = 1'b0;
    check("nop_wrap", 32'(op_count), 32'd0);
    @(posedge clk); #1;
    nop_phase = 1'b0;
    check("nop_rf_quiet", 32'(nz), 32'd0);
    check("sb_drained", 32'(sb.size()), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
